// File: rtl/contador_checker_if.sv
// Signal bundle between a contador instance and its checker.
// The master side drives the observed counter signals; the slave is the checker.
interface contador_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             ENB;
  logic [1:0]       MODO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             ERR;
  logic [7:0]       ERR_CNT;
  logic             FAULT;
  logic [CNT_W-1:0] CHK_CNT;
  logic [CNT_W-1:0] RCO_CNT;
  logic [WIDTH:0]   FAIL_EXP;
  logic [WIDTH:0]   FAIL_OBS;
  logic [1:0]       FAIL_MODO;

  modport master (
    output ENB, MODO, D, Q, RCO,
    input  ERR, ERR_CNT, FAULT, CHK_CNT, RCO_CNT, FAIL_EXP, FAIL_OBS, FAIL_MODO
  );

  modport slave (
    input  ENB, MODO, D, Q, RCO,
    output ERR, ERR_CNT, FAULT, CHK_CNT, RCO_CNT, FAIL_EXP, FAIL_OBS, FAIL_MODO
  );
endinterface

// File: rtl/contador_checker.sv
// Monitor that predicts the contador's next Q/RCO and flags mismatches one cycle later.
// Define CONTADOR_CHK_CAPTURE_EN to build the first-failure capture registers (FAIL_*).
module contador_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_LIMIT = 8,
  parameter int CNT_W     = 16
) (
  input logic CLK,
  input logic RESET_N,
  contador_checker_if.slave bus
);

  localparam logic [7:0] LIMIT = 8'(ERR_LIMIT);

  typedef enum logic [1:0] {UNSYNC, TRACK, FAULT_ST} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] exp_q, exp_q_next;
  logic             exp_rco, exp_rco_next;
  logic             err, err_next;
  logic [7:0]       err_cnt, err_cnt_next;
  logic             fault, fault_next;
  logic [CNT_W-1:0] chk_cnt, chk_cnt_next;
  logic [CNT_W-1:0] rco_cnt, rco_cnt_next;
  logic             mismatch;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= UNSYNC;
      exp_q   <= '0;
      exp_rco <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      fault   <= 1'b0;
      chk_cnt <= '0;
      rco_cnt <= '0;
    end else begin
      state   <= state_next;
      exp_q   <= exp_q_next;
      exp_rco <= exp_rco_next;
      err     <= err_next;
      err_cnt <= err_cnt_next;
      fault   <= fault_next;
      chk_cnt <= chk_cnt_next;
      rco_cnt <= rco_cnt_next;
    end
  end

  // Prediction always starts from the observed Q, so one corruption costs one ERR.
  always_comb begin
    exp_q_next   = bus.Q;
    exp_rco_next = bus.RCO;
    if (bus.ENB) begin
      case (bus.MODO)
        2'b00: begin
          exp_q_next   = bus.Q + 1'b1;
          exp_rco_next = &bus.Q;
        end
        2'b01: begin
          exp_q_next   = bus.Q - 1'b1;
          exp_rco_next = ~|bus.Q;
        end
        2'b10: begin
          exp_q_next   = bus.Q - WIDTH'(3);
          exp_rco_next = 1'b0;
        end
        default: begin
          exp_q_next   = bus.D;
          exp_rco_next = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_next   = state;
    err_next     = 1'b0;
    err_cnt_next = err_cnt;
    fault_next   = fault;
    chk_cnt_next = chk_cnt;
    rco_cnt_next = rco_cnt;
    mismatch     = ({bus.RCO, bus.Q} != {exp_rco, exp_q});
    case (state)
      UNSYNC: state_next = TRACK;
      TRACK: begin
        if (chk_cnt != '1) chk_cnt_next = chk_cnt + 1'b1;
        if (bus.RCO && (rco_cnt != '1)) rco_cnt_next = rco_cnt + 1'b1;
        if (mismatch) begin
          err_next = 1'b1;
          if (err_cnt != 8'hFF) err_cnt_next = err_cnt + 1'b1;
          if (err_cnt_next == LIMIT) begin
            state_next = FAULT_ST;
            fault_next = 1'b1;
          end
        end
      end
      FAULT_ST: fault_next = 1'b1;
      default:  state_next = UNSYNC;
    endcase
  end

`ifdef CONTADOR_CHK_CAPTURE_EN
  logic [1:0]     pred_modo;
  logic           first_seen;
  logic [WIDTH:0] fail_exp, fail_obs;
  logic [1:0]     fail_modo;

  // Only the first mismatch since reset is kept for post-mortem debug.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pred_modo  <= 2'b00;
      first_seen <= 1'b0;
      fail_exp   <= '0;
      fail_obs   <= '0;
      fail_modo  <= 2'b00;
    end else begin
      pred_modo <= bus.MODO;
      if ((state == TRACK) && mismatch && !first_seen) begin
        first_seen <= 1'b1;
        fail_exp   <= {exp_rco, exp_q};
        fail_obs   <= {bus.RCO, bus.Q};
        fail_modo  <= pred_modo;
      end
    end
  end

  assign bus.FAIL_EXP  = fail_exp;
  assign bus.FAIL_OBS  = fail_obs;
  assign bus.FAIL_MODO = fail_modo;
`else
  assign bus.FAIL_EXP  = '0;
  assign bus.FAIL_OBS  = '0;
  assign bus.FAIL_MODO = 2'b00;
`endif

  assign bus.ERR     = err;
  assign bus.ERR_CNT = err_cnt;
  assign bus.FAULT   = fault;
  assign bus.CHK_CNT = chk_cnt;
  assign bus.RCO_CNT = rco_cnt;

endmodule

// File: tb/tb_contador_checker.sv
// Directed bench for contador_checker: a behavioural counter feeds Q/RCO and
// corruptions are injected as state jumps. ERR_LIMIT is set to 3 here.
module tb_contador_checker;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] q_m;
  logic       rco_m;
  int         checks;
  int         failures;

  contador_checker_if #(.WIDTH(4), .CNT_W(16)) bus ();

  contador_checker #(.WIDTH(4), .ERR_LIMIT(3), .CNT_W(16)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  assign bus.Q   = q_m;
  assign bus.RCO = rco_m;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the counter: inputs set before the edge, model advances just after.
  task automatic applyStimulus(input logic enb, input logic [1:0] modo, input logic [3:0] d);
    bus.ENB  = enb;
    bus.MODO = modo;
    bus.D    = d;
    @(posedge CLK);
    #1;
    if (enb) begin
      case (modo)
        2'b00: begin rco_m = (q_m == 4'hF); q_m = q_m + 4'd1; end
        2'b01: begin rco_m = (q_m == 4'h0); q_m = q_m - 4'd1; end
        2'b10: begin rco_m = 1'b0; q_m = q_m - 4'd3; end
        default: begin rco_m = 1'b0; q_m = d; end
      endcase
    end
  endtask

  task automatic resetDut();
    RESET_N = 1'b0;
    q_m     = 4'h0;
    rco_m   = 1'b0;
    repeat (2) @(posedge CLK);
    #3 RESET_N = 1'b1;
  endtask

  task automatic checkFail(input string tag, input logic [4:0] fexp, input logic [4:0] fobs,
                           input logic [1:0] fmodo);
`ifdef CONTADOR_CHK_CAPTURE_EN
    checkOutput({tag, "_fail_exp"}, 32'(bus.FAIL_EXP), 32'(fexp));
    checkOutput({tag, "_fail_obs"}, 32'(bus.FAIL_OBS), 32'(fobs));
    checkOutput({tag, "_fail_modo"}, 32'(bus.FAIL_MODO), 32'(fmodo));
`else
    checkOutput({tag, "_fail_exp"}, 32'(bus.FAIL_EXP), 32'(fexp & 5'h00));
    checkOutput({tag, "_fail_obs"}, 32'(bus.FAIL_OBS), 32'(fobs & 5'h00));
    checkOutput({tag, "_fail_modo"}, 32'(bus.FAIL_MODO), 32'(fmodo & 2'b00));
`endif
  endtask

  initial begin
    logic [3:0] corrupt [3];
    checks   = 0;
    failures = 0;
    bus.ENB  = 1'b0;
    bus.MODO = 2'b00;
    bus.D    = 4'h0;
    resetDut();

    checkOutput("rst_err", 32'(bus.ERR), 32'd0);
    checkOutput("rst_err_cnt", 32'(bus.ERR_CNT), 32'd0);
    checkOutput("rst_fault", 32'(bus.FAULT), 32'd0);
    checkOutput("rst_chk_cnt", 32'(bus.CHK_CNT), 32'd0);
    checkOutput("rst_rco_cnt", 32'(bus.RCO_CNT), 32'd0);

    // Load A then count up across the wrap
    applyStimulus(1'b1, 2'b11, 4'hA);
    checkOutput("up_unsync_chk", 32'(bus.CHK_CNT), 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'b00, 4'h0);
      checkOutput("up_err", 32'(bus.ERR), 32'd0);
    end
    checkOutput("up_chk_cnt", 32'(bus.CHK_CNT), 32'd8);
    checkOutput("up_rco_cnt", 32'(bus.RCO_CNT), 32'd1);
    checkOutput("up_err_cnt", 32'(bus.ERR_CNT), 32'd0);

    // Load 2 then count by -3: F,C,9,6,3,0,D
    applyStimulus(1'b1, 2'b11, 4'h2);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 2'b10, 4'h0);
      checkOutput("m3_err", 32'(bus.ERR), 32'd0);
    end
    checkOutput("m3_chk_cnt", 32'(bus.CHK_CNT), 32'd16);
    checkOutput("m3_rco_cnt", 32'(bus.RCO_CNT), 32'd1);
    checkOutput("m3_err_cnt", 32'(bus.ERR_CNT), 32'd0);

    // Hold at 7, then jump Q to 8 while disabled
    applyStimulus(1'b1, 2'b11, 4'h7);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b11, 4'h7);
      checkOutput("hold_err", 32'(bus.ERR), 32'd0);
    end
    q_m = 4'h8;
    applyStimulus(1'b0, 2'b11, 4'h7);
    checkOutput("hold_bad_err", 32'(bus.ERR), 32'd1);
    checkOutput("hold_bad_err_cnt", 32'(bus.ERR_CNT), 32'd1);
    checkOutput("hold_bad_chk_cnt", 32'(bus.CHK_CNT), 32'd23);
    checkFail("hold", 5'h07, 5'h08, 2'b11);
    applyStimulus(1'b0, 2'b11, 4'h7);
    checkOutput("hold_after_err", 32'(bus.ERR), 32'd0);

    // Count down from 0 with RCO stuck low
    resetDut();
    applyStimulus(1'b1, 2'b01, 4'h0);
    rco_m = 1'b0;
    applyStimulus(1'b1, 2'b11, 4'h5);
    checkOutput("dn_err", 32'(bus.ERR), 32'd1);
    checkOutput("dn_err_cnt", 32'(bus.ERR_CNT), 32'd1);
    checkFail("dn", 5'h1F, 5'h0F, 2'b01);
    applyStimulus(1'b1, 2'b11, 4'h5);
    checkOutput("dn_after_err", 32'(bus.ERR), 32'd0);
    checkOutput("dn_after_err_cnt", 32'(bus.ERR_CNT), 32'd1);

    // Three corruptions reach ERR_LIMIT=3
    resetDut();
    corrupt = '{4'h9, 4'h3, 4'h6};
    applyStimulus(1'b1, 2'b11, 4'h4);
    for (int i = 0; i < 3; i++) begin
      q_m = corrupt[i];
      applyStimulus(1'b0, 2'b00, 4'h0);
      checkOutput("lim_err", 32'(bus.ERR), 32'd1);
      checkOutput("lim_err_cnt", 32'(bus.ERR_CNT), 32'(i + 1));
      checkOutput("lim_fault", 32'(bus.FAULT), (i == 2) ? 32'd1 : 32'd0);
      if (i < 2) begin
        applyStimulus(1'b0, 2'b00, 4'h0);
        checkOutput("lim_gap_err", 32'(bus.ERR), 32'd0);
      end
    end
    checkOutput("lim_chk_cnt", 32'(bus.CHK_CNT), 32'd5);
    checkFail("lim", 5'h04, 5'h09, 2'b11);
    for (int i = 0; i < 2; i++) begin
      q_m = q_m + 4'd5;
      applyStimulus(1'b0, 2'b00, 4'h0);
      checkOutput("flt_err", 32'(bus.ERR), 32'd0);
      checkOutput("flt_err_cnt", 32'(bus.ERR_CNT), 32'd3);
      checkOutput("flt_chk_cnt", 32'(bus.CHK_CNT), 32'd5);
      checkOutput("flt_fault", 32'(bus.FAULT), 32'd1);
    end

    // Asynchronous reset in the middle of a cycle while in FAULT
    #3 RESET_N = 1'b0;
    #1;
    checkOutput("ar_fault", 32'(bus.FAULT), 32'd0);
    checkOutput("ar_err_cnt", 32'(bus.ERR_CNT), 32'd0);
    checkOutput("ar_chk_cnt", 32'(bus.CHK_CNT), 32'd0);
    checkOutput("ar_rco_cnt", 32'(bus.RCO_CNT), 32'd0);
    checkFail("ar", 5'h00, 5'h00, 2'b00);
    q_m   = 4'h0;
    rco_m = 1'b0;
    @(posedge CLK);
    #3 RESET_N = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'h0);
    checkOutput("ar_first_edge_chk", 32'(bus.CHK_CNT), 32'd0);
    checkOutput("ar_first_edge_err", 32'(bus.ERR), 32'd0);
    q_m = 4'h7;
    applyStimulus(1'b1, 2'b00, 4'h0);
    checkOutput("ar_second_edge_chk", 32'(bus.CHK_CNT), 32'd1);
    checkOutput("ar_second_edge_err", 32'(bus.ERR), 32'd1);
    checkOutput("ar_second_edge_err_cnt", 32'(bus.ERR_CNT), 32'd1);
    checkFail("ar2", 5'h01, 5'h07, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
